// File: rtl/vga_pkg.sv
// Shared VGA timing constants, text-grid geometry and the cell address helper
// used by the text renderer and the raster timing generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int CHAR_W_LOG2 = $clog2(CHAR_W);
    localparam int CHAR_H_LOG2 = $clog2(CHAR_H);
    localparam int COLS        = 80;
    localparam int ROWS        = 30;
    localparam int CELLS       = COLS * ROWS;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = $clog2(CELLS);

    typedef logic [6:0]        col_t;
    typedef logic [4:0]        row_t;
    typedef logic [7:0]        ascii_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Row-major cell index; callers guarantee row/col are inside the grid.
    function automatic addr_t cell_addr(input int row, input int col);
        return addr_t'(row * COLS + col);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with sync and active-region generation; shared with other
// display modes. Counters hold at 0,0 until run is asserted.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output cnt_t hcnt,
    output cnt_t vcnt,
    output logic active,
    output logic hs,
    output logic vs
);

    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t hcnt_reg, hcnt_next;
    cnt_t vcnt_reg, vcnt_next;

    always_comb begin
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        if (!run) begin
            hcnt_next = '0;
            vcnt_next = '0;
        end else if (hcnt_reg == H_LAST) begin
            hcnt_next = '0;
            vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + cnt_t'(1);
        end else begin
            hcnt_next = hcnt_reg + cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_reg <= '0;
            vcnt_reg <= '0;
        end else begin
            hcnt_reg <= hcnt_next;
            vcnt_reg <= vcnt_next;
        end
    end

    assign hcnt   = hcnt_reg;
    assign vcnt   = vcnt_reg;
    assign active = (hcnt_reg < cnt_t'(H_ACTIVE)) && (vcnt_reg < cnt_t'(V_ACTIVE));
    assign hs     = !((hcnt_reg >= HS_START) && (hcnt_reg < HS_END));
    assign vs     = !((vcnt_reg >= VS_START) && (vcnt_reg < VS_END));

endmodule

// File: rtl/vga_text_renderer.sv
// 80x30 text-mode renderer: scans the raster, looks glyph bits up in an external
// CharLUT and emits one monochrome pixel per clock with aligned syncs.
module vga_text_renderer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_val,
    output logic       wr_rdy,
    input  col_t       wr_col,
    input  row_t       wr_row,
    input  ascii_t     wr_char,
    output ascii_t     lut_ascii_char,
    output logic [3:0] lut_vidx,
    output logic [2:0] lut_hidx,
    input  logic       lut_lit,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_val,
    output logic       pix_lit
);

    // Reset release is resynchronised so every flop leaves reset on the same edge.
    logic sync_q1_reg, run_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1_reg <= 1'b0;
            run_reg     <= 1'b0;
        end else begin
            sync_q1_reg <= 1'b1;
            run_reg     <= sync_q1_reg;
        end
    end

    cnt_t hcnt, vcnt;
    logic active, hs_raw, vs_raw;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst    (rst),
        .run    (run_reg),
        .hcnt   (hcnt),
        .vcnt   (vcnt),
        .active (active),
        .hs     (hs_raw),
        .vs     (vs_raw)
    );

    // Single-port buffer: writer only gets the port while the raster is blanked.
    logic   wr_in_range, wr_en;
    addr_t  rd_addr, wr_addr, ram_addr;
    ascii_t rd_data_reg;
    ascii_t text_mem [CELLS];

    assign wr_rdy      = !active;
    assign wr_in_range = (wr_col < col_t'(COLS)) && (wr_row < row_t'(ROWS));
    assign wr_en       = wr_val && wr_rdy && wr_in_range;
    assign rd_addr     = cell_addr(int'(vcnt >> CHAR_H_LOG2), int'(hcnt >> CHAR_W_LOG2));
    assign wr_addr     = cell_addr(int'(wr_row), int'(wr_col));
    assign ram_addr    = wr_en ? wr_addr : rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            text_mem[ram_addr] <= wr_char;
        end
        rd_data_reg <= text_mem[ram_addr];
    end

    logic [2:0] hidx1_reg;
    logic [3:0] vidx1_reg;
    logic       active1_reg, hs1_reg, vs1_reg, s1_vld_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hidx1_reg   <= '0;
            vidx1_reg   <= '0;
            active1_reg <= 1'b0;
            hs1_reg     <= 1'b1;
            vs1_reg     <= 1'b1;
            s1_vld_reg  <= 1'b0;
        end else if (!run_reg) begin
            hidx1_reg   <= '0;
            vidx1_reg   <= '0;
            active1_reg <= 1'b0;
            hs1_reg     <= 1'b1;
            vs1_reg     <= 1'b1;
            s1_vld_reg  <= 1'b0;
        end else begin
            hidx1_reg   <= hcnt[2:0];
            vidx1_reg   <= vcnt[3:0];
            active1_reg <= active;
            hs1_reg     <= hs_raw;
            vs1_reg     <= vs_raw;
            s1_vld_reg  <= 1'b1;
        end
    end

    // RAM output has no reset, so it is masked by a resettable stage-1 flag.
    assign lut_ascii_char = s1_vld_reg ? rd_data_reg : '0;
    assign lut_vidx       = vidx1_reg;
    assign lut_hidx       = hidx1_reg;

    logic hsync_reg, vsync_reg, pix_val_reg, pix_lit_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_reg   <= 1'b1;
            vsync_reg   <= 1'b1;
            pix_val_reg <= 1'b0;
            pix_lit_reg <= 1'b0;
        end else begin
            hsync_reg   <= hs1_reg;
            vsync_reg   <= vs1_reg;
            pix_val_reg <= active1_reg;
            pix_lit_reg <= active1_reg & lut_lit;
        end
    end

    assign hsync   = hsync_reg;
    assign vsync   = vsync_reg;
    assign pix_val = pix_val_reg;
    assign pix_lit = pix_lit_reg;

endmodule
